// File: rtl/ps2_pkg.sv
// rtl/ps2_pkg.sv - shared scan codes, parser states and control indices
package ps2_pkg;

   localparam logic [7:0] PS2_E0         = 8'hE0;
   localparam logic [7:0] PS2_E1         = 8'hE1;
   localparam logic [7:0] PS2_F0         = 8'hF0;
   localparam logic [7:0] PS2_AA         = 8'hAA;
   localparam logic [7:0] PS2_FC         = 8'hFC;
   localparam logic [7:0] PS2_FAKE_SHIFT = 8'h12;

   localparam logic [7:0] PS2_LEFT  = 8'h6B;
   localparam logic [7:0] PS2_RIGHT = 8'h74;
   localparam logic [7:0] PS2_UP    = 8'h75;
   localparam logic [7:0] PS2_SPACE = 8'h29;
   localparam logic [7:0] PS2_ENTER = 8'h5A;
   localparam logic [7:0] PS2_ESC   = 8'h76;

   localparam int CTL_LEFT  = 0;
   localparam int CTL_RIGHT = 1;
   localparam int CTL_JUMP  = 2;
   localparam int CTL_START = 3;
   localparam int CTL_ESC   = 4;
   localparam int CTL_NUM   = 5;

   // E1 is followed by seven more bytes of the Pause make/break burst
   localparam logic [2:0] PAUSE_TAIL = 3'd7;

   typedef enum logic [2:0] {IDLE, EXT, BRK, EXT_BRK, SKIP} ps2_state_e;

   // Internal key vector carries the up-arrow jump source in the extra top bit
   function automatic logic [CTL_NUM-1:0] fold_keys(input logic [CTL_NUM:0] k);
      logic [CTL_NUM-1:0] f;
      f           = k[CTL_NUM-1:0];
      f[CTL_JUMP] = k[CTL_JUMP] | k[CTL_NUM];
      return f;
   endfunction

endpackage

// File: rtl/ps2_code_map.sv
// rtl/ps2_code_map.sv - Set-2 scan code to game control select
module ps2_code_map
   import ps2_pkg::*;
(
   input  logic               ext,
   input  logic [7:0]         code,
   output logic [CTL_NUM-1:0] sel,
   output logic               jump_up
);

   always_comb begin
      sel     = '0;
      jump_up = 1'b0;
      if (ext) begin
         case (code)
            PS2_LEFT:  sel[CTL_LEFT]  = 1'b1;
            PS2_RIGHT: sel[CTL_RIGHT] = 1'b1;
            PS2_UP: begin
               sel[CTL_JUMP] = 1'b1;
               jump_up       = 1'b1;
            end
            PS2_ENTER: sel[CTL_START] = 1'b1;
            default: ;
         endcase
      end else begin
         case (code)
            PS2_SPACE: sel[CTL_JUMP]  = 1'b1;
            PS2_ENTER: sel[CTL_START] = 1'b1;
            PS2_ESC:   sel[CTL_ESC]   = 1'b1;
            default: ;
         endcase
      end
   end

endmodule

// File: rtl/ps2_key_tracker.sv
// rtl/ps2_key_tracker.sv - PS/2 make/break parser producing held levels and press pulses
module ps2_key_tracker
   import ps2_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 2000000,
   parameter int TO_WIDTH       = 21
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [15:0]        key,
   input  logic               new_event,
   output logic [CTL_NUM-1:0] held,
   output logic [CTL_NUM-1:0] pressed,
   output logic               seq_error
);

   localparam logic [TO_WIDTH-1:0] TO_LAST = TO_WIDTH'(TIMEOUT_CYCLES - 1);

   ps2_state_e            state_q, state_d;
   logic [CTL_NUM:0]      keys_q, keys_d, hit;
   logic [TO_WIDTH-1:0]   to_q, to_d;
   logic [2:0]            skip_q, skip_d;
   logic [CTL_NUM-1:0]    pressed_q, pressed_d;
   logic                  err_q, err_d;
   logic [CTL_NUM-1:0]    sel;
   logic                  jump_up;
   logic [7:0]            b;
   logic                  unused_key_hi;

   assign b             = key[7:0];
   assign unused_key_hi = ^key[15:8];

   ps2_code_map u_map (
      .ext     ((state_q == EXT) || (state_q == EXT_BRK)),
      .code    (b),
      .sel     (sel),
      .jump_up (jump_up)
   );

   always_comb begin
      hit = {1'b0, sel};
      if (jump_up) begin
         hit[CTL_JUMP] = 1'b0;
         hit[CTL_NUM]  = sel[CTL_JUMP];
      end
   end

   always_comb begin
      state_d = state_q;
      keys_d  = keys_q;
      skip_d  = skip_q;
      to_d    = '0;
      err_d   = 1'b0;
      if (new_event) begin
         case (state_q)
            IDLE: begin
               case (b)
                  PS2_E0: state_d = EXT;
                  PS2_F0: state_d = BRK;
                  PS2_E1: begin
                     state_d = SKIP;
                     skip_d  = PAUSE_TAIL;
                  end
                  PS2_AA:  keys_d = '0;
                  PS2_FC:  err_d  = 1'b1;
                  default: keys_d = keys_q | hit;
               endcase
            end
            EXT: begin
               state_d = IDLE;
               if (b == PS2_F0)              state_d = EXT_BRK;
               else if (b != PS2_FAKE_SHIFT) keys_d  = keys_q | hit;
            end
            BRK: begin
               state_d = IDLE;
               keys_d  = keys_q & ~hit;
            end
            EXT_BRK: begin
               state_d = IDLE;
               if (b != PS2_FAKE_SHIFT) keys_d = keys_q & ~hit;
            end
            SKIP: begin
               skip_d = skip_q - 3'd1;
               if (skip_q <= 3'd1) state_d = IDLE;
            end
            default: state_d = IDLE;
         endcase
      end else if (state_q != IDLE) begin
         // A strobe landing on the expiry cycle takes the branch above instead
         if (to_q == TO_LAST) begin
            state_d = IDLE;
            skip_d  = '0;
            err_d   = 1'b1;
         end else begin
            to_d = to_q + TO_WIDTH'(1);
         end
      end
      pressed_d = fold_keys(keys_d) & ~fold_keys(keys_q);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         keys_q    <= '0;
         to_q      <= '0;
         skip_q    <= '0;
         pressed_q <= '0;
         err_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         keys_q    <= keys_d;
         to_q      <= to_d;
         skip_q    <= skip_d;
         pressed_q <= pressed_d;
         err_q     <= err_d;
      end
   end

   assign held      = fold_keys(keys_q);
   assign pressed   = pressed_q;
   assign seq_error = err_q;

endmodule

// File: tb/tb_ps2_key_tracker.sv
// tb/tb_ps2_key_tracker.sv - directed vector bench for ps2_key_tracker
module tb_ps2_key_tracker;

   localparam int TO = 50;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [15:0] key = '0;
   logic        new_event = 1'b0;
   logic [4:0]  held, pressed;
   logic        seq_error;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic [7:0] b;
      logic [4:0] h;
      logic [4:0] p;
      logic       e;
   } vec_t;

   vec_t vt[$];

   always #5 clk = ~clk;

   ps2_key_tracker #(.TIMEOUT_CYCLES(TO), .TO_WIDTH(6)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .key       (key),
      .new_event (new_event),
      .held      (held),
      .pressed   (pressed),
      .seq_error (seq_error)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic add(input logic [7:0] b, input logic [4:0] h, input logic [4:0] p, input logic e);
      vec_t v;
      v.b = b; v.h = h; v.p = p; v.e = e;
      vt.push_back(v);
   endtask

   task automatic drive_byte(input logic [7:0] b);
      key[15:8] = 8'($urandom_range(0, 255));
      key[7:0]  = b;
      new_event = 1'b1;
   endtask

   // Strobe one byte for one cycle; returns 1 ns after the edge that consumed it
   task automatic send(input logic [7:0] b);
      @(posedge clk); #1;
      drive_byte(b);
      @(posedge clk); #1;
      new_event = 1'b0;
   endtask

   task automatic do_reset();
      @(posedge clk); #1;
      rst_n = 1'b0;
      new_event = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b1;
   endtask

   initial begin
      int pos, cnt;

      #2;
      chk("reset held", held, 5'b0);
      chk("reset pressed", pressed, 5'b0);
      chk("reset seq_error", seq_error, 1'b0);
      @(posedge clk); #1;
      rst_n = 1'b1;

      add(8'hE0, 5'b00000, 5'b00000, 0);
      add(8'h6B, 5'b00001, 5'b00001, 0);
      add(8'hE0, 5'b00001, 5'b00000, 0);
      add(8'hF0, 5'b00001, 5'b00000, 0);
      add(8'h6B, 5'b00000, 5'b00000, 0);
      add(8'h29, 5'b00100, 5'b00100, 0);
      add(8'h29, 5'b00100, 5'b00000, 0);
      add(8'h29, 5'b00100, 5'b00000, 0);
      add(8'hE0, 5'b00100, 5'b00000, 0);
      add(8'h75, 5'b00100, 5'b00000, 0);
      add(8'hF0, 5'b00100, 5'b00000, 0);
      add(8'h29, 5'b00100, 5'b00000, 0);
      add(8'hE0, 5'b00100, 5'b00000, 0);
      add(8'hF0, 5'b00100, 5'b00000, 0);
      add(8'h75, 5'b00000, 5'b00000, 0);
      add(8'hE1, 5'b00000, 5'b00000, 0);
      add(8'h14, 5'b00000, 5'b00000, 0);
      add(8'h77, 5'b00000, 5'b00000, 0);
      add(8'hE1, 5'b00000, 5'b00000, 0);
      add(8'hF0, 5'b00000, 5'b00000, 0);
      add(8'h14, 5'b00000, 5'b00000, 0);
      add(8'hF0, 5'b00000, 5'b00000, 0);
      add(8'h77, 5'b00000, 5'b00000, 0);
      add(8'h76, 5'b10000, 5'b10000, 0);
      add(8'h5A, 5'b11000, 5'b01000, 0);
      add(8'hE0, 5'b11000, 5'b00000, 0);
      add(8'h5A, 5'b11000, 5'b00000, 0);
      add(8'hE0, 5'b11000, 5'b00000, 0);
      add(8'h12, 5'b11000, 5'b00000, 0);
      add(8'hE0, 5'b11000, 5'b00000, 0);
      add(8'h74, 5'b11010, 5'b00010, 0);
      add(8'hFC, 5'b11010, 5'b00000, 1);
      add(8'hF0, 5'b11010, 5'b00000, 0);
      add(8'h6B, 5'b11010, 5'b00000, 0);
      add(8'hAA, 5'b00000, 5'b00000, 0);
      add(8'hE0, 5'b00000, 5'b00000, 0);
      add(8'hF0, 5'b00000, 5'b00000, 0);
      add(8'h12, 5'b00000, 5'b00000, 0);
      add(8'h76, 5'b10000, 5'b10000, 0);
      add(8'hF0, 5'b10000, 5'b00000, 0);
      add(8'h76, 5'b00000, 5'b00000, 0);

      foreach (vt[i]) begin
         send(vt[i].b);
         chk($sformatf("vec%0d held", i), held, vt[i].h);
         chk($sformatf("vec%0d pressed", i), pressed, vt[i].p);
         chk($sformatf("vec%0d seq_error", i), seq_error, vt[i].e);
      end

      // press pulse lasts exactly one cycle
      do_reset();
      send(8'hE0);
      send(8'h6B);
      chk("left pulse", pressed, 5'b00001);
      @(posedge clk); #1;
      chk("left pulse gone", pressed, 5'b00000);
      chk("left still held", held, 5'b00001);

      // back-to-back strobes: E0, 6B, 29 in consecutive cycles
      do_reset();
      @(posedge clk); #1; drive_byte(8'hE0);
      @(posedge clk); #1; drive_byte(8'h6B);
      @(posedge clk); #1; drive_byte(8'h29);
      chk("b2b pressed left", pressed, 5'b00001);
      @(posedge clk); #1; new_event = 1'b0;
      chk("b2b pressed jump", pressed, 5'b00100);
      chk("b2b held", held, 5'b00101);

      // timeout: error exactly once, TO cycles after the strobe cycle ends
      do_reset();
      send(8'hE0);
      pos = -1; cnt = 0;
      for (int k = 0; k < TO + 20; k++) begin
         if (seq_error) begin
            cnt++;
            if (pos < 0) pos = k;
         end
         @(posedge clk); #1;
      end
      chk("timeout pulse count", cnt, 1);
      chk("timeout pulse cycle", pos, TO);
      send(8'h6B);
      chk("after timeout held", held, 5'b00000);
      chk("after timeout pressed", pressed, 5'b00000);

      // strobe on the expiry cycle is parsed and suppresses the error
      do_reset();
      send(8'hE0);
      repeat (TO - 2) @(posedge clk);
      send(8'h6B);
      chk("expiry strobe held", held, 5'b00001);
      cnt = 0;
      for (int k = 0; k < 5; k++) begin
         if (seq_error) cnt++;
         @(posedge clk); #1;
      end
      chk("expiry strobe no error", cnt, 0);

      // asynchronous reset mid-hold, then mid-sequence
      do_reset();
      send(8'hE0);
      send(8'h74);
      chk("right held", held, 5'b00010);
      #2 rst_n = 1'b0;
      #1;
      chk("async reset held", held, 5'b00000);
      @(posedge clk); #1;
      rst_n = 1'b1;
      send(8'hF0);
      send(8'h5A);
      chk("break after reset held", held, 5'b00000);
      send(8'hE0);
      do_reset();
      send(8'h74);
      chk("E0 lost across reset", held, 5'b00000);

      // BAT pass clears left+right
      send(8'hE0); send(8'h6B);
      send(8'hE0); send(8'h74);
      chk("pre-AA held", held, 5'b00011);
      send(8'hAA);
      chk("AA clears held", held, 5'b00000);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

endmodule
